// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test sequencer.
`timescale 1ns/1ps
package alu_bist_pkg;

    localparam int DATA_W = 8;
    localparam int SIG_W  = 16;

    // Feedback taps for x^16+x^14+x^13+x^11+1 in a shift-left register (bits 15,13,12,10)
    localparam logic [SIG_W-1:0] TAP_MASK     = 16'hB400;
    localparam logic [SIG_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } bist_state_e;

    typedef enum logic {
        LFSR_GEN,
        LFSR_MISR
    } lfsr_mode_e;

    // One Fibonacci step: shift left, parity of the tapped bits enters bit 0
    function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] v);
        return {v[SIG_W-2:0], ^(v & TAP_MASK)};
    endfunction

endpackage

// File: rtl/alu_bist_lfsr16.sv
// 16-bit LFSR used both as pattern generator and as multiple-input signature register.
`timescale 1ns/1ps
module bist_lfsr16
    import alu_bist_pkg::*;
#(
    parameter lfsr_mode_e       MODE      = LFSR_GEN,
    parameter logic [SIG_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [SIG_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic [SIG_W-1:0] data_i,
    output logic [SIG_W-1:0] state_o
);

    logic [SIG_W-1:0] state_q;
    logic [SIG_W-1:0] state_d;
    logic [SIG_W-1:0] inject;

    // A pure generator never folds external data into its state
    assign inject = (MODE == LFSR_MISR) ? data_i : '0;

    // Load has priority over stepping so a new run always starts from a known value
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            state_d = lfsr_step(state_q) ^ inject;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST sequencer: drives LFSR patterns into the ALU, compacts results, checks the signature.
`timescale 1ns/1ps
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int               NUM_PATTERNS = 256,
    parameter int               ALU_LAT      = 1,
    parameter int               OP_W         = 3,
    parameter logic [SIG_W-1:0] SEED         = DEFAULT_SEED,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bist_start,
    output logic              alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic              bist_fail,
    output logic [SIG_W-1:0]  signature
);

    localparam logic [15:0] LAST_PAT   = 16'(NUM_PATTERNS - 1);
    localparam logic [15:0] LAST_DRAIN = 16'(ALU_LAT - 1);

    bist_state_e       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ALU_LAT-1:0] vld_q;
    logic              start_q;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic              start_req;
    logic              gen_load, gen_en, misr_load;
    logic [SIG_W-1:0]  lfsr_val, misr_val;

    // A held start line counts once: only its rising edge is a request
    assign start_req = bist_start & ~start_q;

    bist_lfsr16 #(
        .MODE      (LFSR_GEN),
        .RESET_VAL (SEED)
    ) u_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (gen_load),
        .load_val_i (SEED),
        .en_i       (gen_en),
        .data_i     ('0),
        .state_o    (lfsr_val)
    );

    bist_lfsr16 #(
        .MODE      (LFSR_MISR),
        .RESET_VAL ('0)
    ) u_misr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (misr_load),
        .load_val_i ('0),
        .en_i       (vld_q[ALU_LAT-1]),
        .data_i     ({7'b0, alu_carry, alu_result}),
        .state_o    (misr_val)
    );

    // Sequencer next state and per-state outputs; the counter is reused for the drain phase
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        sig_d        = sig_q;
        gen_load     = 1'b0;
        gen_en       = 1'b0;
        misr_load    = 1'b0;
        alu_sel      = 1'b0;
        alu_in_valid = 1'b0;
        bist_busy    = 1'b0;
        bist_done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_req) state_d = S_SEED;
            end
            S_SEED: begin
                alu_sel   = 1'b1;
                bist_busy = 1'b1;
                gen_load  = 1'b1;
                misr_load = 1'b1;
                cnt_d     = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                alu_sel      = 1'b1;
                bist_busy    = 1'b1;
                alu_in_valid = 1'b1;
                gen_en       = 1'b1;
                if (cnt_q == LAST_PAT) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                alu_sel   = 1'b1;
                bist_busy = 1'b1;
                if (cnt_q == LAST_DRAIN) begin
                    cnt_d   = '0;
                    state_d = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_COMPARE: begin
                alu_sel   = 1'b1;
                bist_busy = 1'b1;
                sig_d     = misr_val;
                pass_d    = (misr_val == GOLDEN_SIG);
                fail_d    = (misr_val != GOLDEN_SIG);
                state_d   = S_DONE;
            end
            S_DONE: begin
                bist_done = 1'b1;
                if (start_req) begin
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    state_d = S_SEED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers; reset abandons any run in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= bist_start;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            sig_q   <= sig_d;
        end
    end

    // Valid delay line matching the ALU latency so each result is compacted exactly once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= alu_in_valid;
            for (int i = 1; i < ALU_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign alu_a     = alu_in_valid ? lfsr_val[DATA_W-1:0] : '0;
    assign alu_b     = alu_in_valid ? lfsr_val[SIG_W-1:DATA_W] : '0;
    assign alu_op    = alu_in_valid ? cnt_q[OP_W-1:0] : '0;
    assign bist_pass = pass_q;
    assign bist_fail = fail_q;
    assign signature = sig_q;

endmodule
